// File: rtl/fifo_pkg.sv
// Shared helpers for the stream FIFO slice.
// Contents:
//   clog2_min1(n) - index width for an n-entry array, never less than 1 bit
//   cnt_width(d)  - width of a counter that must represent 0..d inclusive
package fifo_pkg;

    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_DEPTH);

endpackage

// File: rtl/fifo_mem.sv
// Circular storage behind the FIFO output register.
// Ports:
//   clk, rst_n           - clock, async active-low reset (address register only)
//   wr_en/wr_addr/wr_data - single write port
//   rd_addr              - next read address, captured at the clock edge
//   rd_data              - word at the captured read address
// The array itself carries no reset so it maps onto RAM resources.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ENTRIES    = 15,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [ENTRIES];
    logic [ADDR_W-1:0]     rd_addr_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_reg <= '0;
        end else begin
            rd_addr_reg <= rd_addr;
        end
    end

    // The registered address always equals the FIFO read pointer, so the head
    // word of memory is ready at the next edge for refilling the output register.
    assign rd_data = mem[rd_addr_reg];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with a registered output stage.
// Ports:
//   clk, rst_n         - clock, async active-low reset
//   flush              - synchronous clear of all contents (drops a same-cycle push)
//   s_valid/s_ready/s_data - upstream slave port (s_ready registered)
//   m_valid/m_ready/m_data - downstream master port (m_valid/m_data registered)
//   count, empty, full, almost_full - registered occupancy status
// Capacity is DEPTH words: DEPTH-1 in memory plus the output register.
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full
);

    localparam int MEM_DEPTH = DEPTH - 1;
    localparam int CNT_W     = cnt_width(DEPTH);
    localparam int PTR_W     = clog2_min1(MEM_DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_THRESH);

    generate
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("stream_fifo: DEPTH must be a power of two and at least 4");
        end
        if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
            $error("stream_fifo: AFULL_THRESH must lie in 1..DEPTH");
        end
        if (DATA_WIDTH < 1) begin : g_bad_width
            $error("stream_fifo: DATA_WIDTH must be at least 1");
        end
    endgenerate

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_reg, state_next;
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  m_valid_reg, m_valid_next;
    logic [DATA_WIDTH-1:0] m_data_reg, m_data_next;
    logic                  s_ready_reg, s_ready_next;
    logic                  empty_reg, empty_next;
    logic                  full_reg, full_next;
    logic                  afull_reg, afull_next;

    logic                  push, pop;
    logic                  mem_has_data;
    logic                  load_out;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign push = s_valid && s_ready_reg;
    assign pop  = m_valid_reg && m_ready;

    // Memory holds count minus whatever sits in the output register.
    assign mem_has_data = count_reg > {{(CNT_W-1){1'b0}}, m_valid_reg};
    // Output register may take a new word when it is empty or being drained.
    assign load_out     = !m_valid_reg || pop;
    // A push bypasses memory only when the output register is free and memory
    // is empty; otherwise it lands in memory behind the older words.
    assign mem_wr_en    = push && !flush && !(load_out && !mem_has_data);

    always_comb begin
        state_next   = state_reg;
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        s_ready_next = s_ready_reg;

        case (state_reg)
            ST_INIT: begin
                // First edge after reset release opens the input.
                state_next   = ST_RUN;
                s_ready_next = 1'b1;
            end
            default: begin
                if (flush) begin
                    wr_ptr_next  = '0;
                    rd_ptr_next  = '0;
                    count_next   = '0;
                    m_valid_next = 1'b0;
                    s_ready_next = 1'b1;
                end else begin
                    if (load_out) begin
                        if (mem_has_data) begin
                            m_data_next  = mem_rd_data;
                            m_valid_next = 1'b1;
                            rd_ptr_next  = ptr_inc(rd_ptr_reg);
                        end else if (push) begin
                            m_data_next  = s_data;
                            m_valid_next = 1'b1;
                        end else begin
                            m_valid_next = 1'b0;
                        end
                    end
                    if (mem_wr_en) begin
                        wr_ptr_next = ptr_inc(wr_ptr_reg);
                    end
                    case ({push, pop})
                        2'b10:   count_next = count_reg + 1'b1;
                        2'b01:   count_next = count_reg - 1'b1;
                        default: count_next = count_reg;
                    endcase
                    s_ready_next = (count_next != CNT_FULL);
                end
            end
        endcase

        empty_next = (count_next == '0);
        full_next  = (count_next == CNT_FULL);
        afull_next = (count_next >= CNT_AFULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_INIT;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            s_ready_reg <= 1'b0;
            empty_reg   <= 1'b1;
            full_reg    <= 1'b0;
            afull_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            m_valid_reg <= m_valid_next;
            m_data_reg  <= m_data_next;
            s_ready_reg <= s_ready_next;
            empty_reg   <= empty_next;
            full_reg    <= full_next;
            afull_reg   <= afull_next;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENTRIES    (MEM_DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (s_data),
        .rd_addr (rd_ptr_next),
        .rd_data (mem_rd_data)
    );

    assign s_ready     = s_ready_reg;
    assign m_valid     = m_valid_reg;
    assign m_data      = m_data_reg;
    assign count       = count_reg;
    assign empty       = empty_reg;
    assign full        = full_reg;
    assign almost_full = afull_reg;

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: accepted words are queued, popped words
// are compared in order, and occupancy status is checked after every edge.
module tb_stream_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          almost_full;

    int            total = 0;
    int            bad = 0;
    int            exp_cnt = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] hold;

    stream_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: record the handshake seen before the edge, advance, then
    // check registered status against the occupancy model.
    task automatic step();
        logic          push;
        logic          pop;
        logic [DW-1:0] e;
        push = s_valid && s_ready;
        pop  = m_valid && m_ready;
        if (flush) begin
            sb_q.delete();
            exp_cnt = 0;
            $display("t=%0t flush", $time);
        end else begin
            if (pop) begin
                e = 'x;
                if (sb_q.size() > 0) e = sb_q.pop_front();
                check_eq("pop_data", {24'b0, m_data}, {24'b0, e});
                exp_cnt--;
            end
            if (push) begin
                sb_q.push_back(s_data);
                exp_cnt++;
            end
            if (push || pop)
                $display("t=%0t push=%0b din=0x%02h pop=%0b dout=0x%02h", $time, push, s_data, pop, m_data);
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("count", 32'(count), 32'(exp_cnt));
        check_eq("empty", 32'(empty), 32'(exp_cnt == 0));
        check_eq("full", 32'(full), 32'(exp_cnt == DEPTH));
        check_eq("almost_full", 32'(almost_full), 32'(exp_cnt >= AF));
        check_eq("s_ready", 32'(s_ready), 32'(exp_cnt != DEPTH));
        check_eq("m_valid", 32'(m_valid), 32'(exp_cnt != 0));
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check_eq({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check_eq({tag, "_m_data"}, 32'(m_data), 32'd0);
        check_eq({tag, "_count"}, 32'(count), 32'd0);
        check_eq({tag, "_empty"}, 32'(empty), 32'd1);
        check_eq({tag, "_full"}, 32'(full), 32'd0);
        check_eq({tag, "_afull"}, 32'(almost_full), 32'd0);
    endtask

    task automatic fill(input int n, input logic [DW-1:0] base);
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_data = base + DW'(i);
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 2 * DEPTH && exp_cnt > 0; k++) step();
        m_ready = 1'b0;
        check_eq("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        step();                         // edge 1: s_ready rises
        s_valid = 1'b1;
        s_data  = 8'hA5;
        step();                         // edge 2: push 0xA5
        s_valid = 1'b0;
        check_eq("a5_data", 32'(m_data), 32'h0000_00A5);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // Fill to capacity, then offer one more word
        fill(DEPTH, 8'h00);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        step();
        s_valid = 1'b0;
        check_eq("full_hold_count", 32'(count), 32'(DEPTH));

        // Single pop from full, then the rest in order
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        step();
        drain();

        // Sustained push+pop at occupancy 8, pointers wrap several times
        fill(8, 8'h30);
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_data = 8'h55 + DW'(i);
            step();
        end
        drain();

        // Output stability under backpressure
        fill(5, 8'h80);
        hold = sb_q[0];
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
            step();
            check_eq("hold_data", 32'(m_data), 32'(hold));
        end
        drain();

        // Flush with a simultaneous push
        fill(10, 8'hC0);
        s_valid = 1'b1;
        s_data  = 8'h77;
        flush   = 1'b1;
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        fill(3, 8'h01);
        drain();

        // Asynchronous reset in the middle of a burst
        fill(6, 8'h90);
        s_valid = 1'b1;
        m_ready = 1'b1;
        s_data  = 8'hB0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        s_valid = 1'b0;
        m_ready = 1'b0;
        sb_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        fill(1, 8'h5A);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Synchronous valid/ready stream FIFO. It is the standard DUT-side buffer between a stimulus source and a consumer in the verification environment: the driver pushes on the slave port, and the monitor/scoreboard observe the master port. It provides registered outputs, AXI-stream-style stability guarantees, occupancy reporting, an almost-full flag and a synchronous flush.

## Interface
- DATA_WIDTH, 8: payload width in bits (≥1).
- DEPTH, 16: total capacity in words, including the output register; power of two, ≥4.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count ≥ this value; range 1..DEPTH.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous assert, active-low reset; deassertion synchronous to clk.
- flush  in  1: synchronous clear of all contents.
- s_valid  in  1: upstream word valid.
- s_ready  out  1: FIFO can accept a word.
- s_data  in  DATA_WIDTH: upstream payload.
- m_valid  out  1: output word valid.
- m_ready  in  1: downstream accepts.
- m_data  out  DATA_WIDTH: output payload, registered.
- count  out  $clog2(DEPTH)+1: words held, 0..DEPTH.
- empty  out  1: count == 0.
- full  out  1: count == DEPTH.
- almost_full  out  1: count ≥ AFULL_THRESH.

## Operation
- Push: s_valid && s_ready at a rising edge. Pop: m_valid && m_ready at a rising edge.
- Storage: a (DEPTH-1)-entry circular memory plus one output register that holds the head word. The output register is refilled from memory, or directly from s_data when memory is empty (bypass).
- Pointers are $clog2(DEPTH-1)-wide indices that wrap modulo DEPTH-1. There is no extra wrap bit; full/empty are derived from count.
- count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. It never exceeds DEPTH and never underflows.
- s_ready is registered and equals !full for the next cycle, after including this cycle's push/pop. Pop when full: s_ready rises in the following cycle. No same-cycle pass-through of ready.
- m_data and m_valid must stay stable while m_valid && !m_ready. m_data is never updated unless the output register is empty or being popped.
- flush: count←0, pointers←0, m_valid←0, s_ready←1 at the next edge. It overrides any push/pop in the same cycle; a word offered with flush is dropped.
- Reset values: s_ready=0, m_valid=0, m_data=0, count=0, empty=1, full=0, almost_full=0. s_ready goes to 1 at the first rising edge after rst_n deasserts, via an internal init flag.
- Reset asserted mid-stream discards all contents immediately (asynchronous).

## Timing
- Latency: a word pushed at edge N into an empty FIFO has m_valid=1 and m_data=word after edge N, i.e. visible in cycle N+1.
- Throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH-1.
- count, empty, full and almost_full are registered and reflect state after the edge; they update in the same cycle as m_valid/s_ready.
- No combinational path from s_valid/m_ready to any output.

## Structure
- Package fifo_pkg: function clog2_min1(int) returning max(1,$clog2(n)), plus localparam CNT_W helpers. No typedefs needed beyond the count width.
- Sub-module fifo_mem: (DEPTH-1)×DATA_WIDTH, one write port and one registered-address read port, with no reset on the array. stream_fifo holds the control FSM: init → run, with flush and reset handling.
- Parameter assertions (elaboration): DEPTH is a power of two and ≥4; 1≤AFULL_THRESH≤DEPTH.

## Test plan
- Reset, then single push 0xA5 at edge 2 → s_ready=1 from edge 1; m_valid=1, m_data=0xA5, count=1 in cycle 3. Pop → empty=1, count=0.
- Push 16 words 0x00..0x0F with m_ready=0 → full=1, s_ready=0 after 16th push; almost_full=1 from count=14. A 17th offered word is not accepted.
- Full FIFO, m_ready=1 for one cycle → 0x00 popped, count=15, s_ready=1 next cycle, full=0; subsequent pops return 0x01..0x0F in order.
- Count at 8, simultaneous push 0x55 and pop for 40 cycles → count stays 8, in-order data, pointers wrap at least twice, no drop or duplicate.
- Count at 5, m_ready=0, random s_valid → m_data constant while m_valid && !m_ready.
- Count at 10, assert flush together with push 0x77 → next cycle count=0, empty=1, m_valid=0, s_ready=1; 0x77 never appears. Separately, assert rst_n low mid-burst → all outputs take reset values immediately.
